// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: BCD digits, load and blink in;
// registered segment and digit-enable lines out.
interface seg_scan_driver_if #(
   parameter int DIGITS = 3
);
   logic [4*DIGITS-1:0] digits_bcd;
   logic                load;
   logic                blink;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   an;

   modport master (
      output digits_bcd, load, blink,
      input  seg, an
   );

   modport slave (
      input  digits_bcd, load, blink,
      output seg, an
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed DIGITS-digit 7-segment driver with BCD shadow and blink.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
   parameter int DIGITS    = 3,
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 64
) (
   input logic         clk,
   input logic         reset,
   seg_scan_driver_if.slave bus
);
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = $clog2(BLINK_DIV + 1);

   typedef enum logic {PH_VISIBLE, PH_DARK} phase_t;

   logic [PW-1:0]       pre;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;
   logic [BW-1:0]       bcnt;
   phase_t              phase;

   logic                pre_wrap;
   logic                scan_done;
   logic [3:0]          cur_digit;
   logic [6:0]          cur_seg;
   logic                blank_lz;
   logic [DIGITS-1:0]   onehot;

   always_comb begin
      pre_wrap  = (pre == PW'(SCAN_DIV - 1));
      scan_done = pre_wrap && (idx == IW'(DIGITS - 1));
      cur_digit = '0;
      onehot    = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_digit = shadow[4*i +: 4];
         end
         onehot[i] = (idx == IW'(i));
      end
   end

   always_comb begin
      blank_lz = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      // Blank when this digit and all above it are zero; digit 0 always shown.
      blank_lz = (idx != '0);
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if ((IW'(i) >= idx) && (shadow[4*i +: 4] != 4'd0)) begin
            blank_lz = 1'b0;
         end
      end
`endif
   end

   always_comb begin
      case (cur_digit)
         4'd0:    cur_seg = 7'h3F;
         4'd1:    cur_seg = 7'h06;
         4'd2:    cur_seg = 7'h5B;
         4'd3:    cur_seg = 7'h4F;
         4'd4:    cur_seg = 7'h66;
         4'd5:    cur_seg = 7'h6D;
         4'd6:    cur_seg = 7'h7D;
         4'd7:    cur_seg = 7'h07;
         4'd8:    cur_seg = 7'h7F;
         4'd9:    cur_seg = 7'h6F;
         default: cur_seg = 7'h00;
      endcase
      if (blank_lz) begin
         cur_seg = 7'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre     <= '0;
         idx     <= '0;
         shadow  <= '0;
         bcnt    <= '0;
         phase   <= PH_VISIBLE;
         bus.seg <= '0;
         bus.an  <= '0;
      end else begin
         if (bus.load) begin
            shadow <= bus.digits_bcd;
         end

         if (pre_wrap) begin
            pre <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            pre <= pre + PW'(1);
         end

         if (!bus.blink) begin
            bcnt  <= '0;
            phase <= PH_VISIBLE;
         end else if (scan_done) begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
               bcnt  <= '0;
               phase <= (phase == PH_DARK) ? PH_VISIBLE : PH_DARK;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
         end

         // Live blink input gates the output so dropping blink shows at once.
         if (bus.blink && (phase == PH_DARK)) begin
            bus.seg <= '0;
            bus.an  <= '0;
         end else begin
            bus.seg <= cur_seg;
            bus.an  <= onehot;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: cycle-index reference model feeds an
// expectation queue, a negedge monitor compares seg/an against it.
module tb_seg_scan_driver;
   localparam int D  = 3;
   localparam int S  = 4;
   localparam int B  = 2;
   localparam int SCAN = D * S;

   typedef struct packed {
      logic [6:0]   seg;
      logic [D-1:0] an;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   seg_scan_driver_if #(.DIGITS(D)) bus ();

   seg_scan_driver #(
      .DIGITS   (D),
      .SCAN_DIV (S),
      .BLINK_DIV(B)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   exp_t q[$];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

   // Model state: edges since reset release, shadow, completed blink scans, phase.
   int unsigned         m_n = 0;
   logic [4*D-1:0]      m_sh = '0;
   int unsigned         m_bc = 0;
   bit                  m_ph = 1'b0;

   initial begin : model
      forever begin
         exp_t        e;
         int unsigned di;
         logic [3:0]  dv;
         @(posedge clk);
         if (reset) begin
            e.seg = '0;
            e.an  = '0;
            q.push_back(e);
            m_n  = 0;
            m_sh = '0;
            m_bc = 0;
            m_ph = 1'b0;
         end else begin
            di = (m_n / S) % D;
            dv = 4'((m_sh >> (4 * di)) & 'hF);
            e.an  = D'(1 << di);
            e.seg = seg_tab[dv];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (di >= 1 && (m_sh >> (4 * di)) == 0) e.seg = '0;
`endif
            if (bus.blink && m_ph) begin
               e.an  = '0;
               e.seg = '0;
            end
            q.push_back(e);
            if (bus.load) m_sh = bus.digits_bcd;
            if (!bus.blink) begin
               m_bc = 0;
               m_ph = 1'b0;
            end else if ((m_n + 1) % SCAN == 0) begin
               m_bc++;
               if (m_bc == B) begin
                  m_bc = 0;
                  m_ph = !m_ph;
               end
            end
            m_n++;
         end
      end
   end

   initial begin : monitor
      forever begin
         exp_t e;
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.seg !== e.seg || bus.an !== e.an) begin
               errors++;
               $display("FAIL outputs t=%0t: seg=%h an=%b, expected seg=%h an=%b",
                        $time, bus.seg, bus.an, e.seg, e.an);
            end
         end
      end
   end

   task automatic tick(input int unsigned k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_load(input logic [4*D-1:0] v);
      bus.digits_bcd = v;
      bus.load = 1'b1;
      tick(1);
      bus.load = 1'b0;
   endtask

   initial begin : stim
      int unsigned waited;
      reset          = 1'b1;
      bus.load       = 1'b0;
      bus.blink      = 1'b0;
      bus.digits_bcd = '0;
      tick(3);
      reset = 1'b0;
      tick(30);

      do_load(12'h782);
      tick(24);
      bus.digits_bcd = 12'h123;
      tick(24);
      do_load(12'h999);
      tick(24);
      do_load(12'h0A1);
      tick(24);
      do_load(12'h005);
      tick(24);
      do_load(12'h050);
      tick(24);
      do_load(12'h000);
      tick(24);
      do_load(12'h782);
      tick(5);

      bus.blink = 1'b1;
      tick(60);
      waited = 0;
      while (!m_ph && waited < 200) begin
         tick(1);
         waited++;
      end
      checks++;
      if (!m_ph) begin
         errors++;
         $display("FAIL dark_wait: phase=%0d after %0d cycles, expected 1", m_ph, waited);
      end
      tick(3);
      bus.blink = 1'b0;
      tick(15);

      bus.blink = 1'b1;
      tick(20);
      waited = 0;
      while ((m_n % SCAN) != 5 && waited < 100) begin
         tick(1);
         waited++;
      end
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(60);

      for (int i = 0; i < 2000; i++) begin
         bus.digits_bcd = 12'($urandom);
         bus.load  = ($urandom_range(7) == 0);
         if ($urandom_range(49) == 0) bus.blink = ~bus.blink;
         reset = ($urandom_range(399) == 0);
         tick(1);
      end
      bus.load  = 1'b0;
      bus.blink = 1'b0;
      reset     = 1'b0;
      tick(3);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
